// File: rtl/spi_mem_slave_if.sv
// spi_mem_slave_if: SPI pins and SRAM client-port signals of the SPI memory front end
interface spi_mem_slave_if;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        mem_begin_rd;
  logic        mem_begin_wr;
  logic        mem_finish;
  logic [19:0] mem_addr;
  logic [7:0]  mem_data_wr;
  logic [7:0]  mem_data_rd;
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, mem_finish, mem_data_rd,
    output spi_miso, spi_miso_oe, mem_begin_rd, mem_begin_wr, mem_addr, mem_data_wr
  );
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, mem_finish, mem_data_rd,
    input  spi_miso, spi_miso_oe, mem_begin_rd, mem_begin_wr, mem_addr, mem_data_wr
  );
endinterface

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: oversampled SPI mode-0 flash-style command decoder driving byte SRAM requests
module spi_mem_slave #(
  parameter logic [23:0] JEDEC_ID    = 24'h202015,
  parameter int          SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  spi_mem_slave_if.slave  bus
);
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_STATUS, S_ID, S_IGNORE} state_t;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  cnt_q, cnt_d, id_q, id_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, pre_q, pre_d, data_wr_q, data_wr_d;
  logic [23:0] addr_q, addr_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic sck_prev_q, sck_prev_d, armed_q, armed_d, done_q, done_d, wel_q, wel_d;
  logic fast_q, fast_d, wr_cmd_q, wr_cmd_d, rd_pend_q, rd_pend_d, req_q, req_d;
  logic begin_rd_q, begin_rd_d, begin_wr_q, begin_wr_d, oe_q, oe_d;
  logic sck_s, cs_s, mosi_s, rise, fall, active;
  logic [7:0] rx_byte;
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign fall   = ~sck_s & sck_prev_q;
  assign active = armed_q & ~cs_s;
  assign bus.spi_miso     = tx_q[7];
  assign bus.spi_miso_oe  = oe_q;
  assign bus.mem_begin_rd = begin_rd_q;
  assign bus.mem_begin_wr = begin_wr_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_wr  = data_wr_q;
  // Synchronize the asynchronous SPI pins; CS resets low so a reset mid-transaction needs a fresh CS high to re-arm
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    end
  end
  // Command decode, shifting, and memory request generation
  always_comb begin
    state_d = state_q; bit_d = bit_q; cnt_d = cnt_q; id_d = id_q;
    rx_d = rx_q; tx_d = tx_q; pre_d = pre_q; data_wr_d = data_wr_q;
    addr_d = addr_q; mem_addr_d = mem_addr_q; done_d = done_q; wel_d = wel_q;
    fast_d = fast_q; wr_cmd_d = wr_cmd_q; rd_pend_d = rd_pend_q; req_d = req_q;
    begin_rd_d = 1'b0; begin_wr_d = 1'b0;
    rx_byte = {rx_q[6:0], mosi_s};
    sck_prev_d = sck_s;
    armed_d = armed_q | cs_s;
    oe_d = active;
    if (!active) begin
      state_d = S_CMD; bit_d = '0; cnt_d = '0; done_d = 1'b0; tx_d = '0;
      rd_pend_d = 1'b0; req_d = 1'b0; wr_cmd_d = 1'b0;
      wel_d = wr_cmd_q ? 1'b0 : wel_q;
    end else begin
      if (bus.mem_finish && rd_pend_q) begin
        pre_d = bus.mem_data_rd;
        rd_pend_d = 1'b0;
      end
      if (req_q) begin
        begin_rd_d = 1'b1; mem_addr_d = addr_q[19:0]; rd_pend_d = 1'b1; req_d = 1'b0;
      end
      if (rise) begin
        rx_d = rx_byte;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          done_d = 1'b1;
          case (state_q)
            S_CMD: begin
              fast_d = 1'b0; id_d = '0; cnt_d = '0;
              case (rx_byte)
                8'h03: state_d = S_ADDR;
                8'h0B: begin state_d = S_ADDR; fast_d = 1'b1; end
                8'h02: begin state_d = S_ADDR; wr_cmd_d = 1'b1; end
                8'h05: state_d = S_STATUS;
                8'h9F: state_d = S_ID;
                8'h06: begin state_d = S_IGNORE; wel_d = 1'b1; end
                8'h04: begin state_d = S_IGNORE; wel_d = 1'b0; end
                default: state_d = S_IGNORE;
              endcase
            end
            S_ADDR: begin
              addr_d = {addr_q[15:0], rx_byte};
              cnt_d = cnt_q + 2'd1;
              if (cnt_q == 2'd2) begin
                state_d = wr_cmd_q ? S_WRITE : fast_q ? S_DUMMY : S_READ;
                req_d = !wr_cmd_q && !fast_q;
              end
            end
            S_DUMMY: begin state_d = S_READ; req_d = 1'b1; end
            S_WRITE: if (wel_q) begin
              data_wr_d = rx_byte; begin_wr_d = 1'b1; mem_addr_d = addr_q[19:0];
              addr_d = {addr_q[23:20], addr_q[19:0] + 20'd1};
            end
            default: ;
          endcase
        end
      end
      if (fall) begin
        tx_d = {tx_q[6:0], 1'b0};
        if (done_q) begin
          done_d = 1'b0;
          tx_d = state_q == S_READ ? pre_q :
                 state_q == S_STATUS ? {6'b0, wel_q, 1'b0} :
                 state_q == S_ID ? (id_q == 2'd0 ? JEDEC_ID[23:16] : id_q == 2'd1 ? JEDEC_ID[15:8] :
                                    id_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00) : 8'h00;
          id_d = (state_q == S_ID && id_q != 2'd3) ? id_q + 2'd1 : id_q;
          if (state_q == S_READ) begin
            addr_d = {addr_q[23:20], addr_q[19:0] + 20'd1};
            req_d = 1'b1;
          end
        end
      end
    end
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CMD; bit_q <= '0; cnt_q <= '0; id_q <= '0;
      rx_q <= '0; tx_q <= '0; pre_q <= '0; data_wr_q <= '0;
      addr_q <= '0; mem_addr_q <= '0; sck_prev_q <= 1'b0; armed_q <= 1'b0;
      done_q <= 1'b0; wel_q <= 1'b0; fast_q <= 1'b0; wr_cmd_q <= 1'b0;
      rd_pend_q <= 1'b0; req_q <= 1'b0; begin_rd_q <= 1'b0; begin_wr_q <= 1'b0; oe_q <= 1'b0;
    end else begin
      state_q <= state_d; bit_q <= bit_d; cnt_q <= cnt_d; id_q <= id_d;
      rx_q <= rx_d; tx_q <= tx_d; pre_q <= pre_d; data_wr_q <= data_wr_d;
      addr_q <= addr_d; mem_addr_q <= mem_addr_d; sck_prev_q <= sck_prev_d; armed_q <= armed_d;
      done_q <= done_d; wel_q <= wel_d; fast_q <= fast_d; wr_cmd_q <= wr_cmd_d;
      rd_pend_q <= rd_pend_d; req_q <= req_d; begin_rd_q <= begin_rd_d; begin_wr_q <= begin_wr_d; oe_q <= oe_d;
    end
  end
endmodule

// File: tb/tb_spi_mem_slave.sv
// tb_spi_mem_slave: directed SPI host sequences against a small SRAM model
module tb_spi_mem_slave;
  logic clk = 1'b0;
  logic reset;
  int n_assert = 0;
  int n_fail = 0;
  spi_mem_slave_if b();
  spi_mem_slave #(.JEDEC_ID(24'h202015), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] sram(input logic [19:0] a);
    return a == 20'hFFFFF ? 8'h5A : a == 20'h00000 ? 8'hC3 : a == 20'h00010 ? 8'h77 : a[7:0] ^ 8'h3C;
  endfunction
  int rd_dly = 0;
  logic [19:0] rd_addr = '0;
  int wr_cnt = 0, rd_cnt = 0;
  logic [19:0] wr_addr_log [16];
  logic [7:0]  wr_data_log [16];
  logic [19:0] rd_addr_log [16];
  logic both_seen = 1'b0, long_seen = 1'b0, oe_seen = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  // SRAM model answering each read three cycles later, plus strobe logging
  always @(posedge clk) begin
    b.mem_finish <= 1'b0;
    if (rd_dly > 0) begin
      rd_dly <= rd_dly - 1;
      if (rd_dly == 1) begin
        b.mem_finish <= 1'b1;
        b.mem_data_rd <= sram(rd_addr);
      end
    end
    if (b.mem_begin_rd) begin
      rd_dly <= 3;
      rd_addr <= b.mem_addr;
      rd_addr_log[rd_cnt % 16] <= b.mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (b.mem_begin_wr) begin
      wr_addr_log[wr_cnt % 16] <= b.mem_addr;
      wr_data_log[wr_cnt % 16] <= b.mem_data_wr;
      wr_cnt <= wr_cnt + 1;
    end
    if (b.mem_begin_rd && b.mem_begin_wr) both_seen <= 1'b1;
    if ((b.mem_begin_rd && prev_rd) || (b.mem_begin_wr && prev_wr)) long_seen <= 1'b1;
    if (b.spi_miso_oe) oe_seen <= 1'b1;
    prev_rd <= b.mem_begin_rd;
    prev_wr <= b.mem_begin_wr;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic xfer_n(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      b.spi_mosi = tx[i];
      tick(12);
      b.spi_sck = 1'b1;
      rx[i] = b.spi_miso;
      tick(12);
      b.spi_sck = 1'b0;
    end
  endtask
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_n(tx, 8, rx);
  endtask
  task automatic send(input logic [7:0] tx);
    logic [7:0] d;
    xfer(tx, d);
  endtask
  task automatic cs_lo;
    b.spi_cs_n = 1'b0;
    tick(6);
  endtask
  task automatic cs_hi;
    tick(12);
    b.spi_cs_n = 1'b1;
    tick(20);
  endtask
  task automatic cmd1(input logic [7:0] c);
    cs_lo(); send(c); cs_hi();
  endtask
  task automatic rdsr(output logic [7:0] s);
    cs_lo(); send(8'h05); xfer(8'h00, s); cs_hi();
  endtask
  initial begin
    logic [7:0] r0, r1, r2, r3;
    int w0, c0;
    reset = 1'b1;
    b.spi_sck = 1'b0; b.spi_cs_n = 1'b1; b.spi_mosi = 1'b0;
    b.mem_finish = 1'b0; b.mem_data_rd = '0;
    tick(5);
    chk("rst_miso", 32'(b.spi_miso), 0);
    chk("rst_oe", 32'(b.spi_miso_oe), 0);
    chk("rst_begin_rd", 32'(b.mem_begin_rd), 0);
    chk("rst_begin_wr", 32'(b.mem_begin_wr), 0);
    chk("rst_addr", 32'(b.mem_addr), 0);
    chk("rst_data_wr", 32'(b.mem_data_wr), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b.spi_sck = ~b.spi_sck; b.spi_mosi = ~b.spi_mosi;
      tick(5);
    end
    b.spi_sck = 1'b0;
    chk("idle_rd", 32'(rd_cnt), 0);
    chk("idle_wr", 32'(wr_cnt), 0);
    chk("idle_oe", 32'(oe_seen), 0);
    cmd1(8'h06);
    rdsr(r0);
    chk("rdsr_after_wren", 32'(r0), 32'h02);
    w0 = wr_cnt;
    cs_lo();
    chk("oe_active", 32'(b.spi_miso_oe), 1);
    send(8'h02); send(8'h00); send(8'h12); send(8'h34); send(8'hAA); send(8'hBB);
    cs_hi();
    chk("oe_after_cs", 32'(b.spi_miso_oe), 0);
    chk("wr_count", 32'(wr_cnt - w0), 2);
    chk("wr0_addr", 32'(wr_addr_log[w0 % 16]), 32'h01234);
    chk("wr0_data", 32'(wr_data_log[w0 % 16]), 32'hAA);
    chk("wr1_addr", 32'(wr_addr_log[(w0 + 1) % 16]), 32'h01235);
    chk("wr1_data", 32'(wr_data_log[(w0 + 1) % 16]), 32'hBB);
    rdsr(r0);
    chk("rdsr_after_write", 32'(r0), 32'h00);
    w0 = wr_cnt;
    cs_lo(); send(8'h02); send(8'h00); send(8'h00); send(8'h20); send(8'h55); cs_hi();
    chk("wr_no_wel", 32'(wr_cnt - w0), 0);
    c0 = rd_cnt;
    cs_lo(); send(8'h03); send(8'h0F); send(8'hFF); send(8'hFF);
    xfer(8'h00, r0); xfer(8'h00, r1); cs_hi();
    chk("rd_byte0", 32'(r0), 32'h5A);
    chk("rd_byte1_wrap", 32'(r1), 32'hC3);
    chk("rd_addr0", 32'(rd_addr_log[c0 % 16]), 32'hFFFFF);
    chk("rd_addr1_wrap", 32'(rd_addr_log[(c0 + 1) % 16]), 32'h00000);
    c0 = rd_cnt;
    cs_lo(); send(8'h0B); send(8'h00); send(8'h00); send(8'h10); send(8'h00);
    xfer(8'h00, r0); cs_hi();
    chk("fast_rd", 32'(r0), 32'h77);
    chk("fast_rd_addr", 32'(rd_addr_log[c0 % 16]), 32'h00010);
    cs_lo(); send(8'h9F);
    xfer(8'h00, r0); xfer(8'h00, r1); xfer(8'h00, r2); xfer(8'h00, r3); cs_hi();
    chk("id0", 32'(r0), 32'h20);
    chk("id1", 32'(r1), 32'h20);
    chk("id2", 32'(r2), 32'h15);
    chk("id3", 32'(r3), 32'h00);
    cmd1(8'h06);
    w0 = wr_cnt;
    cs_lo(); send(8'h02); send(8'h00); send(8'h00); send(8'h40); send(8'hAA);
    xfer_n(8'hFF, 5, r0); cs_hi();
    chk("partial_wr_count", 32'(wr_cnt - w0), 1);
    chk("partial_wr_addr", 32'(wr_addr_log[w0 % 16]), 32'h00040);
    chk("partial_wr_data", 32'(wr_data_log[w0 % 16]), 32'hAA);
    rdsr(r0);
    chk("rdsr_after_partial", 32'(r0), 32'h00);
    cmd1(8'h06);
    cs_lo();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("midrst_oe", 32'(b.spi_miso_oe), 0);
    chk("midrst_addr", 32'(b.mem_addr), 0);
    send(8'h05); xfer(8'h00, r0);
    chk("midrst_ignored", 32'(r0), 32'h00);
    chk("midrst_oe_held", 32'(b.spi_miso_oe), 0);
    cs_hi();
    rdsr(r0);
    chk("midrst_wel_cleared", 32'(r0), 32'h00);
    cmd1(8'h06);
    rdsr(r0);
    chk("rdsr_final", 32'(r0), 32'h02);
    chk("never_both_strobes", 32'(both_seen), 0);
    chk("strobe_one_cycle", 32'(long_seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
